lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: runs one load/store at a time on the data bus, checks alignment and formats load data; LSU_TIMEOUT_EN adds an ack timeout.
// Latency: accept T0, bus_req_o from T1, done_o one cycle after the ack is sampled (3 cycles minimum).
// Backpressure: stall_o holds the pipeline from the accept cycle until the ack is sampled; bus_req_o is held until bus_ack_i.
`ifndef MEM_RW
`define MEM_RW 2
`endif
`ifndef MEM_DISABLE
`define MEM_DISABLE 2'd0
`endif
`ifndef MEM_READ
`define MEM_READ 2'd1
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'd2
`endif
`ifndef BYTE_SEL
`define BYTE_SEL 2
`endif
`ifndef SL_NONE
`define SL_NONE 2'd0
`endif
`ifndef SL_BYTE
`define SL_BYTE 2'd1
`endif
`ifndef SL_HALFWORD
`define SL_HALFWORD 2'd2
`endif
`ifndef SL_WORD
`define SL_WORD 2'd3
`endif
`ifndef UNSIGNED
`define UNSIGNED 1'b1
`endif

module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  input  logic [`MEM_RW-1:0]   mem_rw_i,
  input  logic [`BYTE_SEL-1:0] byte_sel_i,
  input  logic                 un_sign_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [4:0]           rd_waddr_i,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [31:0]          bus_addr_o,
  output logic [31:0]          bus_wdata_o,
  output logic [3:0]           bus_be_o,
  input  logic                 bus_ack_i,
  input  logic [31:0]          bus_rdata_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [31:0]          rdata_o,
  output logic [4:0]           rd_waddr_o,
  output logic                 misalign_o,
  output logic                 fault_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state, state_nxt;
  size_t       sz_in, sz_q;
  logic        req_hit, mis_in, start, ack_hit, timeout, stall_c;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, ld_shift, ld_fmt;
  logic [1:0]  off_q;
  logic        uns_q, we_q, misalign_q;
  logic [31:0] rdata_q;
  logic [4:0]  rd_q;

  // SL_NONE on a real access behaves as a word access
  always_comb begin
    case (byte_sel_i)
      `SL_BYTE:     sz_in = SZ_B;
      `SL_HALFWORD: sz_in = SZ_H;
      default:      sz_in = SZ_W;
    endcase
  end

  assign mis_in  = ((sz_in == SZ_H) && addr_i[0]) || ((sz_in == SZ_W) && (addr_i[1:0] != 2'b00));
  assign req_hit = (state == IDLE) && req_valid_i && (mem_rw_i != `MEM_DISABLE);
  assign start   = req_hit && !mis_in;
  assign ack_hit = (state == BUSY) && bus_ack_i;

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = wdata_i;
    case (sz_in)
      SZ_B: begin
        be_in    = 4'b0001 << addr_i[1:0];
        wdata_in = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_in    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_in = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_shift = bus_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld_fmt = ld_shift;
    case (sz_q)
      SZ_B:    ld_fmt = uns_q ? {24'd0, ld_shift[7:0]}   : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_fmt = uns_q ? {16'd0, ld_shift[15:0]}  : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
  logic          fault_q;

  assign timeout = (state == BUSY) && !bus_ack_i && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      fault_q  <= timeout;
      wait_cnt <= (state == BUSY && !bus_ack_i) ? wait_cnt + CW'(1) : '0;
    end
  end

  assign fault_o = fault_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timeout        = 1'b0;
  assign fault_o        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          stall_c   = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (bus_ack_i)    state_nxt = RESP;
        else if (timeout) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sz_q        <= SZ_B;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_wdata_o <= 32'd0;
      bus_be_o    <= 4'd0;
      rd_q        <= 5'd0;
      rdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      misalign_q <= req_hit && mis_in;
      if (start) begin
        sz_q        <= sz_in;
        off_q       <= addr_i[1:0];
        uns_q       <= (un_sign_i == `UNSIGNED);
        we_q        <= (mem_rw_i == `MEM_WRITE);
        bus_addr_o  <= {addr_i[31:2], 2'b00};
        bus_wdata_o <= wdata_in;
        bus_be_o    <= be_in;
        rd_q        <= (mem_rw_i == `MEM_WRITE) ? 5'd0 : rd_waddr_i;
      end
      if (ack_hit && !we_q) rdata_q <= ld_fmt;
    end
  end

  // Reset gates stall_o because req_valid_i may already be high while rst is low
  assign stall_o    = stall_c & rst;
  assign bus_req_o  = (state == BUSY);
  assign bus_we_o   = we_q;
  assign done_o     = (state == RESP);
  assign rdata_o    = rdata_q;
  assign rd_waddr_o = rd_q;
  assign misalign_o = misalign_q;

endmodule
